// File: rtl/pixel_sink_framebuffer.sv
// pixel_sink_framebuffer
// Receives a stream of plotted pixels into an on-chip WIDTH x HEIGHT frame
// store. The same store can be scanned out in raster order as a pixel stream.
// A hardware clear sequence blanks every location to colour 0.
// Write path: input register -> address register -> memory write.
// The scan path has a one-cycle synchronous read.

module pixel_sink_framebuffer #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int COLOUR_BITS = 3
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   i_plot,
    input  logic [7:0]             i_x_in,
    input  logic [7:0]             i_y_in,
    input  logic [COLOUR_BITS-1:0] i_colour_in,
    input  logic                   i_clear_req,
    output logic                   o_clear_busy,
    output logic [15:0]            o_clip_count,
    input  logic                   i_scan_en,
    output logic                   o_pix_valid,
    output logic [7:0]             o_pix_x,
    output logic [7:0]             o_pix_y,
    output logic [COLOUR_BITS-1:0] o_pix_colour,
    output logic                   o_frame_start
);

    localparam int DEPTH  = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
    localparam logic [7:0]        X_LAST    = 8'(WIDTH - 1);
    localparam logic [7:0]        Y_LAST    = 8'(HEIGHT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Clear sequencer
    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              w_clr_start;
    logic              w_clr_we;
    logic              w_busy;
    logic              w_flush;

    // Write pipeline
    logic                   w_in_range;
    logic                   r_s1_valid;
    logic [7:0]             r_s1_x;
    logic [7:0]             r_s1_y;
    logic [COLOUR_BITS-1:0] r_s1_colour;
    logic [ADDR_W-1:0]      w_s1_addr;
    logic                   r_s2_valid;
    logic [ADDR_W-1:0]      r_s2_addr;
    logic [COLOUR_BITS-1:0] r_s2_colour;
    logic [15:0]            r_clip_count;

    // Memory write port
    logic                   w_we;
    logic [ADDR_W-1:0]      w_waddr;
    logic [COLOUR_BITS-1:0] w_wdata;
    logic [COLOUR_BITS-1:0] r_mem [0:DEPTH-1];

    // Raster scan
    logic [7:0]             r_sx;
    logic [7:0]             r_sy;
    logic [ADDR_W-1:0]      r_scan_addr;
    logic                   r_pix_valid;
    logic [7:0]             r_pix_x;
    logic [7:0]             r_pix_y;
    logic [COLOUR_BITS-1:0] r_pix_colour;
    logic                   r_frame_start;

    assign w_busy  = (r_state == CLEAR);
    // Anything in the write pipeline when a clear starts, or during it, is thrown away.
    assign w_flush = w_clr_start || w_busy;

    // Clear FSM state register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Clear FSM next state and per-cycle controls
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_clr_start  = 1'b0;
        w_clr_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_clear_req) begin
                    w_next_state = CLEAR;
                    w_clr_start  = 1'b1;
                end
            end
            CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_addr == LAST_ADDR) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Clear address counter: zeroed on entry, one address per busy cycle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_clr_addr <= '0;
        end else if (w_clr_start) begin
            r_clr_addr <= '0;
        end else if (w_clr_we) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    assign w_in_range = (32'(i_x_in) < 32'(WIDTH)) && (32'(i_y_in) < 32'(HEIGHT));

    // Stage 1: capture the plot; only in-range plots outside a clear stay valid
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s1_valid  <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_colour <= '0;
        end else begin
            r_s1_valid  <= i_plot && w_in_range && !w_flush;
            r_s1_x      <= i_x_in;
            r_s1_y      <= i_y_in;
            r_s1_colour <= i_colour_in;
        end
    end

    // Saturating count of out-of-range plots; plots dropped by a clear do not count
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_clip_count <= '0;
        end else if (i_plot && !w_busy && !w_in_range && (r_clip_count != 16'hFFFF)) begin
            r_clip_count <= r_clip_count + 16'd1;
        end
    end

    assign w_s1_addr = ADDR_W'(r_s1_y) * WIDTH_A + ADDR_W'(r_s1_x);

    // Stage 2: register the linear address of the pixel
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s2_valid  <= 1'b0;
            r_s2_addr   <= '0;
            r_s2_colour <= '0;
        end else begin
            r_s2_valid  <= r_s1_valid && !w_flush;
            r_s2_addr   <= w_s1_addr;
            r_s2_colour <= r_s1_colour;
        end
    end

    // Single write port shared by the clear sequencer and the plot pipeline
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_s2_addr;
        w_wdata = r_s2_colour;
        if (w_clr_we) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = '0;
        end else if (r_s2_valid && !w_flush) begin
            w_we = 1'b1;
        end
    end

    // Frame store write
    // NOTE: the frame store has no reset; its contents survive resetn and only the clear sequence blanks it.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Raster scan counters: column, row and the matching linear address
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_sx        <= '0;
            r_sy        <= '0;
            r_scan_addr <= '0;
        end else if (i_scan_en) begin
            if (r_sx == X_LAST) begin
                r_sx <= '0;
                if (r_sy == Y_LAST) begin
                    r_sy <= '0;
                end else begin
                    r_sy <= r_sy + 8'd1;
                end
            end else begin
                r_sx <= r_sx + 8'd1;
            end
            r_scan_addr <= (r_scan_addr == LAST_ADDR) ? '0 : r_scan_addr + 1'b1;
        end
    end

    // Scan output register: synchronous read plus aligned coordinates and markers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_colour  <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_valid   <= i_scan_en;
            r_frame_start <= i_scan_en && (r_sx == 8'd0) && (r_sy == 8'd0);
            if (i_scan_en) begin
                r_pix_x      <= r_sx;
                r_pix_y      <= r_sy;
                // NOTE: the write above is non-blocking, so a same-edge read of that address returns the old word.
                r_pix_colour <= r_mem[r_scan_addr];
            end
        end
    end

    assign o_clear_busy  = w_busy;
    assign o_clip_count  = r_clip_count;
    assign o_pix_valid   = r_pix_valid;
    assign o_pix_x       = r_pix_x;
    assign o_pix_y       = r_pix_y;
    assign o_pix_colour  = r_pix_colour;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_pixel_sink_framebuffer.sv
// Testbench for pixel_sink_framebuffer.
// The reference model is a plain array holding the whole frame.
// It also keeps a saturating clip counter and a linear scan position.
// Scans are compared against the model pixel by pixel.

module tb_pixel_sink_framebuffer;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       resetn;
    logic       i_plot;
    logic [7:0] i_x_in;
    logic [7:0] i_y_in;
    logic [2:0] i_colour_in;
    logic       i_clear_req;
    logic       o_clear_busy;
    logic [15:0] o_clip_count;
    logic       i_scan_en;
    logic       o_pix_valid;
    logic [7:0] o_pix_x;
    logic [7:0] o_pix_y;
    logic [2:0] o_pix_colour;
    logic       o_frame_start;

    pixel_sink_framebuffer #(.WIDTH(W), .HEIGHT(H), .COLOUR_BITS(3)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .i_plot        (i_plot),
        .i_x_in        (i_x_in),
        .i_y_in        (i_y_in),
        .i_colour_in   (i_colour_in),
        .i_clear_req   (i_clear_req),
        .o_clear_busy  (o_clear_busy),
        .o_clip_count  (o_clip_count),
        .i_scan_en     (i_scan_en),
        .o_pix_valid   (o_pix_valid),
        .o_pix_x       (o_pix_x),
        .o_pix_y       (o_pix_y),
        .o_pix_colour  (o_pix_colour),
        .o_frame_start (o_frame_start)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] model [N];
    logic [2:0] cap   [N];
    int         clip_m;
    int         scan_pos;

    // Advance one clock; outputs are then sampled 1 unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference behaviour of one accepted plot cycle while the buffer is idle.
    task automatic model_plot(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
        if (int'(x) < W && int'(y) < H) begin
            model[int'(y) * W + int'(x)] = c;
        end else if (clip_m < 65535) begin
            clip_m++;
        end
    endtask

    task automatic pick_oob(output logic [7:0] x, output logic [7:0] y);
        case ($urandom_range(0, 2))
            0: begin x = 8'($urandom_range(W, 255)); y = 8'($urandom_range(0, 255)); end
            1: begin x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(H, 255)); end
            default: begin x = 8'($urandom_range(W, 255)); y = 8'($urandom_range(H, 255)); end
        endcase
    endtask

    task automatic plot_one(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
        i_plot = 1'b1; i_x_in = x; i_y_in = y; i_colour_in = c;
        model_plot(x, y, c);
        step();
    endtask

    task automatic idle(input int n);
        i_plot = 1'b0;
        repeat (n) step();
    endtask

    // Scan n pixels from the current position, optionally flooding out-of-range plots.
    task automatic scan_n(input int n, input bit flood, input string tag);
        int bad = 0, fs_seen = 0, fs_want = 0, valids = 0;
        int fb_pos = -1;
        logic [7:0] ex, ey, fx, fy, px, py;
        logic [2:0] ec, fc, pc;
        logic fv, ffs;
        fx = '0; fy = '0; fc = '0; fv = 1'b0; ffs = 1'b0;
        for (int i = 0; i < n; i++) begin
            i_scan_en = 1'b1;
            if (flood) begin
                pick_oob(px, py);
                pc = 3'($urandom);
                i_plot = 1'b1; i_x_in = px; i_y_in = py; i_colour_in = pc;
                model_plot(px, py, pc);
            end
            step();
            ex = 8'(scan_pos % W);
            ey = 8'(scan_pos / W);
            ec = model[scan_pos];
            cap[scan_pos] = o_pix_colour;
            if (o_pix_valid === 1'b1) valids++;
            if (o_frame_start === 1'b1) fs_seen++;
            if (scan_pos == 0) fs_want++;
            if (o_pix_valid !== 1'b1 || o_pix_x !== ex || o_pix_y !== ey ||
                o_pix_colour !== ec || o_frame_start !== 1'(scan_pos == 0)) begin
                if (bad == 0) begin
                    fb_pos = scan_pos; fx = o_pix_x; fy = o_pix_y;
                    fc = o_pix_colour; fv = o_pix_valid; ffs = o_frame_start;
                end
                bad++;
            end
            scan_pos = (scan_pos + 1) % N;
        end
        i_scan_en = 1'b0;
        i_plot    = 1'b0;

        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL scan_%s: %0d bad pixels, first at index %0d got v=%0b x=%0d y=%0d c=%0d fs=%0b want x=%0d y=%0d c=%0d",
                     tag, bad, fb_pos, fv, fx, fy, fc, ffs, fb_pos % W, fb_pos / W, model[fb_pos]);
        end
        n_checks++;
        if (valids !== n) begin
            n_errors++;
            $display("FAIL scan_%s_valid_count: got %0d want %0d", tag, valids, n);
        end
        n_checks++;
        if (fs_seen !== fs_want) begin
            n_errors++;
            $display("FAIL scan_%s_frame_start_count: got %0d want %0d", tag, fs_seen, fs_want);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; i_plot = 1'b0; i_x_in = '0; i_y_in = '0; i_colour_in = '0;
        i_clear_req = 1'b0; i_scan_en = 1'b0;
        step();
        step();
        clip_m   = 0;
        scan_pos = 0;
        n_checks++;
        if (o_clear_busy !== 1'b0) begin n_errors++; $display("FAIL reset_clear_busy: got %0b want 0", o_clear_busy); end
        n_checks++;
        if (o_clip_count !== 16'd0) begin n_errors++; $display("FAIL reset_clip_count: got %0d want 0", o_clip_count); end
        n_checks++;
        if (o_pix_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pix_valid: got %0b want 0", o_pix_valid); end
        n_checks++;
        if (o_pix_x !== 8'd0 || o_pix_y !== 8'd0) begin n_errors++; $display("FAIL reset_pix_xy: got (%0d,%0d) want (0,0)", o_pix_x, o_pix_y); end
        n_checks++;
        if (o_pix_colour !== 3'd0) begin n_errors++; $display("FAIL reset_pix_colour: got %0d want 0", o_pix_colour); end
        n_checks++;
        if (o_frame_start !== 1'b0) begin n_errors++; $display("FAIL reset_frame_start: got %0b want 0", o_frame_start); end
        resetn = 1'b1;
    endtask

    // Full clear with a dropped plot, a dropped out-of-range plot and an ignored second request.
    task automatic test_clear_no_restart();
        int busy_cycles = 0;
        i_clear_req = 1'b1;
        step();
        i_clear_req = 1'b0;
        while (o_clear_busy === 1'b1 && busy_cycles < 20000) begin
            busy_cycles++;
            i_plot      = (busy_cycles == 3) || (busy_cycles == 5);
            i_x_in      = (busy_cycles == 5) ? 8'd200 : 8'd1;
            i_y_in      = 8'd1;
            i_colour_in = 3'b111;
            i_clear_req = (busy_cycles == 100);
            step();
        end
        i_plot      = 1'b0;
        i_clear_req = 1'b0;
        for (int i = 0; i < N; i++) model[i] = 3'd0;
        n_checks++;
        if (busy_cycles !== N) begin n_errors++; $display("FAIL clear_busy_length: got %0d want %0d", busy_cycles, N); end
        n_checks++;
        if (o_clip_count !== 16'(clip_m)) begin n_errors++; $display("FAIL clear_clip_unchanged: got %0d want %0d", o_clip_count, clip_m); end
    endtask

    task automatic test_clip_count();
        plot_one(8'd160, 8'd0,   3'b001);
        plot_one(8'd0,   8'd120, 3'b010);
        plot_one(8'd255, 8'd255, 3'b011);
        i_plot = 1'b0;
        n_checks++;
        if (o_clip_count !== 16'd3) begin n_errors++; $display("FAIL clip_three: got %0d want 3", o_clip_count); end
    endtask

    // Whole-frame scan of the cleared buffer while out-of-range plots flood in,
    // then keep flooding to 65540 rejected plots in total.
    task automatic test_clip_saturate();
        logic [7:0] px, py;
        scan_n(N, 1'b1, "frame_zero");
        n_checks++;
        if (o_clip_count !== 16'(clip_m)) begin n_errors++; $display("FAIL clip_mid_flood: got %0d want %0d", o_clip_count, clip_m); end
        for (int i = 0; i < 65540 - N; i++) begin
            pick_oob(px, py);
            plot_one(px, py, 3'($urandom));
        end
        i_plot = 1'b0;
        n_checks++;
        if (o_clip_count !== 16'hFFFF) begin n_errors++; $display("FAIL clip_saturate: got %0h want ffff", o_clip_count); end
    endtask

    task automatic test_single_plot();
        plot_one(8'd5, 8'd7, 3'b101);
        idle(3);
        scan_n(8 * W - scan_pos, 1'b0, "single");
        n_checks++;
        if (cap[7 * W + 5] !== 3'b101) begin n_errors++; $display("FAIL single_5_7: got %0d want 5", cap[7 * W + 5]); end
        n_checks++;
        if (cap[7 * W + 4] !== 3'b000) begin n_errors++; $display("FAIL single_4_7: got %0d want 0", cap[7 * W + 4]); end
        n_checks++;
        if (cap[6 * W + 5] !== 3'b000) begin n_errors++; $display("FAIL single_5_6: got %0d want 0", cap[6 * W + 5]); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int dy = 0; dy < 8; dy++) begin
            for (int dx = 0; dx < 8; dx++) begin
                plot_one(8'(10 + dx), 8'(20 + dy), 3'b010);
            end
        end
        idle(3);
        scan_n(29 * W - scan_pos, 1'b0, "square");
        for (int dy = 0; dy < 8; dy++) begin
            for (int dx = 0; dx < 8; dx++) begin
                if (cap[(20 + dy) * W + 10 + dx] !== 3'b010) bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL square_pixels: got %0d wrong of 64 want 0 wrong", bad); end
        n_checks++;
        if (cap[20 * W + 18] !== 3'b000) begin n_errors++; $display("FAIL square_18_20: got %0d want 0", cap[20 * W + 18]); end
    endtask

    // Random mix of in-range plots (rows 29..34), rejected plots and idle cycles.
    task automatic test_random_plots();
        logic [7:0] px, py;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: idle(1);
                1: begin pick_oob(px, py); plot_one(px, py, 3'($urandom)); end
                default: plot_one(8'($urandom_range(0, W - 1)), 8'($urandom_range(29, 34)), 3'($urandom));
            endcase
        end
        idle(3);
        scan_n(35 * W - scan_pos, 1'b0, "random");
        n_checks++;
        if (o_clip_count !== 16'(clip_m)) begin n_errors++; $display("FAIL random_clip: got %0d want %0d", o_clip_count, clip_m); end
    endtask

    task automatic test_scan_gap_and_reset();
        resetn = 1'b0; i_scan_en = 1'b0; i_plot = 1'b0;
        step();
        resetn   = 1'b1;
        clip_m   = 0;
        scan_pos = 0;
        scan_n(159, 1'b0, "row0");
        i_scan_en = 1'b1;
        step();
        n_checks++;
        if (o_pix_valid !== 1'b1 || o_pix_x !== 8'd159 || o_pix_y !== 8'd0 || o_pix_colour !== model[159]) begin
            n_errors++; $display("FAIL gap_before: got v=%0b (%0d,%0d) c=%0d want v=1 (159,0) c=%0d", o_pix_valid, o_pix_x, o_pix_y, o_pix_colour, model[159]);
        end
        i_scan_en = 1'b0;
        step();
        n_checks++;
        if (o_pix_valid !== 1'b0 || o_pix_x !== 8'd159 || o_pix_y !== 8'd0 || o_pix_colour !== model[159]) begin
            n_errors++; $display("FAIL gap_hold: got v=%0b (%0d,%0d) c=%0d want v=0 (159,0) c=%0d", o_pix_valid, o_pix_x, o_pix_y, o_pix_colour, model[159]);
        end
        i_scan_en = 1'b1;
        step();
        n_checks++;
        if (o_pix_valid !== 1'b1 || o_pix_x !== 8'd0 || o_pix_y !== 8'd1 || o_pix_colour !== model[W]) begin
            n_errors++; $display("FAIL gap_after: got v=%0b (%0d,%0d) c=%0d want v=1 (0,1) c=%0d", o_pix_valid, o_pix_x, o_pix_y, o_pix_colour, model[W]);
        end
        i_scan_en = 1'b0;
        scan_pos  = W + 1;
        scan_n(37, 1'b0, "row1");
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        scan_pos = 0;
        n_checks++;
        if (o_pix_valid !== 1'b0 || o_pix_x !== 8'd0 || o_pix_y !== 8'd0 || o_clip_count !== 16'd0) begin
            n_errors++; $display("FAIL midframe_reset: got v=%0b (%0d,%0d) clip=%0d want v=0 (0,0) clip=0", o_pix_valid, o_pix_x, o_pix_y, o_clip_count);
        end
        i_scan_en = 1'b1;
        step();
        i_scan_en = 1'b0;
        n_checks++;
        if (o_pix_valid !== 1'b1 || o_pix_x !== 8'd0 || o_pix_y !== 8'd0 || o_frame_start !== 1'b1 || o_pix_colour !== model[0]) begin
            n_errors++; $display("FAIL restart_origin: got v=%0b (%0d,%0d) fs=%0b c=%0d want v=1 (0,0) fs=1 c=%0d",
                                 o_pix_valid, o_pix_x, o_pix_y, o_frame_start, o_pix_colour, model[0]);
        end
        scan_pos = 1;
        scan_n(20, 1'b0, "restart");
    endtask

    initial begin
        test_reset();
        test_clear_no_restart();
        test_clip_count();
        test_clip_saturate();
        test_single_plot();
        test_back_to_back();
        test_random_plots();
        test_scan_gap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_sink_framebuffer.md
Name: pixel_sink_framebuffer

Overview:
- Receiving end of the square-drawing pixel stream: consumes per-pixel x/y/colour/plot writes and stores them in an on-chip WIDTH x HEIGHT frame buffer.
- Also scans the buffer out in raster order as a pixel stream with valid, coordinates and frame-start marker, for display or readback.
- Provides a hardware clear sequence that blanks the whole buffer.

Parameters:
- WIDTH, 160, pixels per row; legal x range 0..WIDTH-1.
- HEIGHT, 120, rows per frame; legal y range 0..HEIGHT-1.
- COLOUR_BITS, 3, bits per stored pixel.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- plot  in  1  write strobe; one pixel accepted per cycle when high.
- x_in  in  8  pixel column.
- y_in  in  8  pixel row.
- colour_in  in  COLOUR_BITS  pixel colour.
- clear_req  in  1  one-cycle pulse; starts a full-buffer clear.
- clear_busy  out  1  high while a clear is in progress.
- clip_count  out  16  saturating count of plot writes rejected as out of range.
- scan_en  in  1  advances the raster read scan when high.
- pix_valid  out  1  pix_x/pix_y/pix_colour are valid this cycle.
- pix_x  out  8  column of the output pixel.
- pix_y  out  8  row of the output pixel.
- pix_colour  out  COLOUR_BITS  stored colour of the output pixel.
- frame_start  out  1  high with pix_valid for pixel (0,0).

Behaviour:
- Reset (resetn=0 at an edge):
  - Outputs clear_busy=0, clip_count=0, pix_valid=0, pix_x=0, pix_y=0, pix_colour=0, frame_start=0.
  - Scan counters go to (0,0). FSM goes to IDLE. Write pipeline valids are cleared.
  - Memory contents are NOT reset.
- Write pipeline, 2 stages:
  - Stage 1 (cycle after plot): registers x, y, colour and valid = plot && x_in<WIDTH && y_in<HEIGHT.
  - If plot is high and the coordinate is out of range, clip_count increments and saturates at 16'hFFFF.
  - Stage 2: addr = y*WIDTH + x, registered, with width ceil(log2(WIDTH*HEIGHT)); 15 bits at the defaults.
  - Stage 3 edge: memory write.
  - A plotted pixel is visible to a read issued 3 cycles after the plot cycle.
  - Back-to-back plots are accepted every cycle; there is no backpressure.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_req; the clear address counter is set to 0 and clear_busy=1 from the next cycle.
  - In CLEAR, writes colour 0 to addr 0, 1, ..., WIDTH*HEIGHT-1, one address per cycle.
  - After the write to the last address: -> IDLE, clear_busy=0.
  - clear_req while in CLEAR is ignored; the clear does not restart.
  - plot while clear_busy=1 is dropped: not written and not counted in clip_count.
  - Write-pipeline entries already in flight when CLEAR starts are discarded.
  - Reset mid-clear: FSM returns to IDLE; the buffer is left partially cleared.
- Raster scan:
  - Internal counters sx, sy. When scan_en=1: sx increments; at sx=WIDTH-1, sx wraps to 0 and sy increments; at (WIDTH-1, HEIGHT-1) both wrap to 0.
  - Memory read is synchronous, 1-cycle latency.
  - pix_valid, pix_x, pix_y and frame_start are registered to align with pix_colour, one cycle after the scan_en cycle that issued the address.
  - scan_en=0: counters hold and pix_valid=0 next cycle. pix_x, pix_y and pix_colour hold their last values.
  - frame_start=1 exactly when pix_valid=1 and pix_x=0 and pix_y=0.
- Same-address read and write in one cycle: the read returns the old data (read-before-write).
- The scan runs during CLEAR; it returns a mix of cleared and uncleared data, and that is legal.

Test Plan:
- Reset, then clear_req pulse -> clear_busy=1 for exactly 19200 cycles. Then scan a full frame: all pix_colour=0, frame_start once at (0,0), 19200 pix_valid pulses.
- plot (x=5, y=7, colour=3'b101) -> scan reaches (5,7) with pix_colour=3'b101. Neighbours (4,7) and (5,6) are still 0.
- 64 consecutive plots forming the 8x8 square at origin (10,20), colour 3'b010, one per cycle -> all 64 locations read 3'b010. Location (18,20) is still 0.
- plot at (160,0), (0,120) and (255,255) -> clip_count=3 and no memory location changes. Drive 65540 out-of-range plots -> clip_count stays at 16'hFFFF.
- clear_req, then plot (1,1,3'b111) and a second clear_req at cycle 100 of the clear -> the plot is dropped, clip_count is unchanged, and clear_busy falls on cycle 19200 (no restart).
- Scan with scan_en toggled 1,0,1 at (159,0) -> pix_x/pix_y sequence 159,0 then 0,1. pix_valid is low for the gap cycle. Assert resetn=0 mid-frame -> next valid pixel is (0,0) with frame_start=1.
